// File: rtl/pulse_stretcher_pkg.sv
// Shared types and sizing helpers for the pulse stretcher.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Timer width is clog2 of the longer interval, never narrower than one bit.
  function automatic int cnt_width(input int h, input int l);
    int m;
    m = (h > l) ? h : l;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pulse_stretcher_interval.sv
// interval_timer: loadable up-counter with terminal-count compare
// against a limit supplied at run time.
module interval_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_load,
  input  logic [W-1:0] i_limit,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // Clear on load (state entry or retrigger), otherwise count up.
  always_ff @(posedge clk_i) begin
    if (rst_i || i_load) r_cnt <= '0;
    else                 r_cnt <= r_cnt + W'(1);
  end

  assign o_tc = (r_cnt == i_limit);

endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns one-cycle events into HIGH_CYCLES-wide levels
// separated by at least LOW_CYCLES low cycles; events arriving while busy
// are counted (saturating at MAX_PENDING) and replayed in order.
// Optional macro PULSE_STRETCHER_RETRIGGER_EN: a pulse during HIGH restarts
// the high interval instead of queueing.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int HIGH_CYCLES = 250000,
  parameter int LOW_CYCLES  = 250000,
  parameter int MAX_PENDING = 7,
  localparam int PW = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          pulse_i,
  output logic          level_o,
  output logic          busy_o,
  output logic [PW-1:0] pending_o,
  output logic          overflow_o
);

  localparam int CW = cnt_width(HIGH_CYCLES, LOW_CYCLES);
  localparam logic [CW-1:0] HI_LIM = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LO_LIM = CW'(LOW_CYCLES - 1);
  localparam logic [PW-1:0] PMAX   = PW'(MAX_PENDING);

  state_e        r_state, w_next;
  logic [PW-1:0] r_pend, w_pend;
  logic          r_level, r_busy, r_ovf;
  logic          w_load, w_tc, w_inc, w_dec, w_ovf;
  logic [CW-1:0] w_limit;

  assign w_limit = (r_state == ST_HIGH) ? HI_LIM : LO_LIM;

  interval_timer #(.W(CW)) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_load  (w_load),
    .i_limit (w_limit),
    .o_tc    (w_tc)
  );

  // Next-state, timer reload and queue increment/decrement requests.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_inc  = 1'b0;
    w_dec  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (pulse_i) begin
          w_next = ST_HIGH;
          w_load = 1'b1;
        end
      end
      ST_HIGH: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        if (pulse_i) begin
          w_load = 1'b1;
        end else if (w_tc) begin
          w_next = ST_GAP;
          w_load = 1'b1;
        end
`else
        w_inc = pulse_i;
        if (w_tc) begin
          w_next = ST_GAP;
          w_load = 1'b1;
        end
`endif
      end
      ST_GAP: begin
        if (w_tc) begin
          if (r_pend != '0) begin
            // Replay a queued event; a coincident pulse queues behind it.
            w_next = ST_HIGH;
            w_load = 1'b1;
            w_dec  = 1'b1;
            w_inc  = pulse_i;
          end else if (pulse_i) begin
            // Empty queue: the pulse is serviced directly.
            w_next = ST_HIGH;
            w_load = 1'b1;
          end else begin
            w_next = ST_IDLE;
            w_load = 1'b1;
          end
        end else begin
          w_inc = pulse_i;
        end
      end
      default: begin
        w_next = ST_IDLE;
        w_load = 1'b1;
      end
    endcase
  end

  // Saturating queue update; simultaneous inc/dec cancel without overflow.
  always_comb begin
    w_pend = r_pend;
    w_ovf  = 1'b0;
    if (w_inc && !w_dec) begin
      if (r_pend == PMAX) w_ovf  = 1'b1;
      else                w_pend = r_pend + PW'(1);
    end else if (w_dec && !w_inc) begin
      w_pend = r_pend - PW'(1);
    end
  end

  // State, queue and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
      r_level <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pend  <= w_pend;
      r_level <= (w_next == ST_HIGH);
      r_busy  <= (w_next != ST_IDLE);
      r_ovf   <= w_ovf;
    end
  end

  assign level_o    = r_level;
  assign busy_o     = r_busy;
  assign pending_o  = r_pend;
  assign overflow_o = r_ovf;

endmodule
